data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store interface. Accepts word-addressed

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_bank.sv | 27 ++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // A store mask is legal only if it is a naturally aligned byte, half or word
  // that agrees with the low address bits.
  function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] addr_lo);
    case (mask)
      MASK_B0: mask_legal = (addr_lo == 2'd0);
      MASK_B1: mask_legal = (addr_lo == 2'd1);
      MASK_B2: mask_legal = (addr_lo == 2'd2);
      MASK_B3: mask_legal = (addr_lo == 2'd3);
      MASK_H0: mask_legal = (addr_lo == 2'd0);
      MASK_H1: mask_legal = (addr_lo == 2'd2);
      MASK_W:  mask_legal = (addr_lo == 2'd0);
      default: mask_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide storage with per-byte write enables and a registered read port.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes and enabled synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits WAIT_STATES cycles, then
// commits the store or returns the read word with a one-cycle ack.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mask,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ack,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t      state;
  logic [3:0]  cnt;
  logic        rd_zero;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_mask;
  logic        req_err;
  logic        enter_resp;
  logic        bank_we;
  logic        bank_re;
  logic [31:0] bank_rdata;

  // With zero wait states the commit edge is the accept edge, so the live
  // inputs stand in for the latches while in IDLE.
  always_comb begin
    cur_we    = (state == IDLE) ? we    : req_we;
    cur_addr  = (state == IDLE) ? addr  : req_addr;
    cur_wdata = (state == IDLE) ? wdata : req_wdata;
    cur_mask  = (state == IDLE) ? mask  : req_mask;
    req_err   = (cur_addr >= LIMIT) || (cur_we && !mask_legal(cur_mask, cur_addr[1:0]));
    enter_resp = ((state == IDLE) && !cs && (WAIT_STATES == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));
    bank_we   = enter_resp && cur_we && !req_err && rst_n;
    bank_re   = enter_resp && !cur_we && !req_err && rst_n;
    stall     = rst_n && (((state == IDLE) && !cs) || (state == WAIT));
    rdata     = rd_zero ? 32'd0 : bank_rdata;
  end

  // Request latches: captured once at accept, never resampled during WAIT.
  always_ff @(posedge clk) begin
    if (state == IDLE && !cs) begin
      req_we    <= we;
      req_addr  <= addr;
      req_wdata <= wdata;
      req_mask  <= mask;
    end
  end

  // Access sequencer with registered ack/err and read-data zeroing flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        ack <= 1'b1;
        err <= req_err;
        if (req_err)     rd_zero <= 1'b1;
        else if (!cur_we) rd_zero <= 1'b0;
      end
    end
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk  (clk),
    .addr (cur_addr[AW+1:2]),
    .we   (bank_we),
    .be   (cur_mask),
    .wdata(cur_wdata),
    .re   (bank_re),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with one wait state, one with none.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cs0, we0, cs1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  mask0, mask1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, ack0, err0, stall1, ack1, err1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] xrd;
    logic        xerr;
  } op_t;

  exp_t sb[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cs(cs0), .we(we0), .addr(addr0), .wdata(wdata0),
    .mask(mask0), .rdata(rdata0), .stall(stall0), .ack(ack0), .err(err0)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .cs(cs1), .we(we1), .addr(addr1), .wdata(wdata1),
    .mask(mask1), .rdata(rdata1), .stall(stall1), .ack(ack1), .err(err1)
  );

  function automatic op_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input logic [31:0] xrd, input logic xerr);
    op_t o;
    o.w = w; o.a = a; o.d = d; o.m = m; o.xrd = xrd; o.xerr = xerr;
    return o;
  endfunction

  function automatic exp_t exp_of(input op_t o);
    exp_t e;
    e.rdata  = o.xrd;
    e.err    = o.xerr;
    e.chk_rd = !o.w || o.xerr;
    return e;
  endfunction

  // Drive one request on u0, hold it until ack (bounded), report what was seen.
  task automatic access(input op_t o, output logic got, output int lat, output int sc,
                        output logic [31:0] rd, output logic e);
    got = 1'b0; lat = 0; sc = 0; rd = '0; e = 1'b0;
    @(negedge clk);
    cs0 = 1'b0; we0 = o.w; addr0 = o.a; wdata0 = o.d; mask0 = o.m;
    #1;
    if (stall0) sc++;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (stall0) sc++;
      if (ack0) begin
        got = 1'b1; lat = i; rd = rdata0; e = err0;
      end
    end
    @(negedge clk);
    cs0 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; mask0 = '0;
    cs1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0; mask1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got %h need 0", rdata0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall0 got %b need 0", stall0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b need 0", ack0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b need 0", err0); end
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata1 got %h need 0", rdata1); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL reset_stall1 got %b need 0", stall1); end
    checks++; if (ack1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL reset_ack_err1 got %b%b need 00", ack1, err1); end
    cs0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    op_t ops[$];
    exp_t ex;
    logic got, e;
    int lat, sc;
    logic [31:0] rd;
    ops.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0));
    foreach (ops[i]) begin
      sb.push_back(exp_of(ops[i]));
      access(ops[i], got, lat, sc, rd, e);
      ex = sb.pop_front();
      checks++; if (!got || lat != 2) begin errors++; $display("FAIL word_latency op%0d ack=%b after %0d need ack after 2", i, got, lat); end
      checks++; if (sc != 2) begin errors++; $display("FAIL word_stall op%0d stall cycles %0d need 2", i, sc); end
      checks++; if (e !== ex.err) begin errors++; $display("FAIL word_err op%0d got %b need %b", i, e, ex.err); end
      if (ex.chk_rd) begin
        checks++; if (rd !== ex.rdata) begin errors++; $display("FAIL word_rdata op%0d got %h need %h", i, rd, ex.rdata); end
      end
    end
  endtask

  task automatic test_byte_merge();
    op_t ops[$];
    exp_t ex;
    logic got, e;
    int lat, sc;
    logic [31:0] rd;
    ops.push_back(mk(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 32'h20, 32'h000000AA, 4'b0001, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 32'h21, 32'h0000BB00, 4'b0010, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 32'h20, 32'h0, 4'b0000, 32'h1122BBAA, 1'b0));
    foreach (ops[i]) begin
      sb.push_back(exp_of(ops[i]));
      access(ops[i], got, lat, sc, rd, e);
      ex = sb.pop_front();
      checks++; if (!got || lat != 2 || sc != 2) begin errors++; $display("FAIL merge_timing op%0d ack=%b lat %0d stall %0d need lat 2 stall 2", i, got, lat, sc); end
      checks++; if (e !== ex.err) begin errors++; $display("FAIL merge_err op%0d got %b need %b", i, e, ex.err); end
      if (ex.chk_rd) begin
        checks++; if (rd !== ex.rdata) begin errors++; $display("FAIL merge_rdata op%0d got %h need %h", i, rd, ex.rdata); end
      end
    end
  endtask

  task automatic test_half_store();
    op_t ops[$];
    exp_t ex;
    logic got, e;
    int lat, sc;
    logic [31:0] rd;
    ops.push_back(mk(1'b1, 32'h30, 32'h99887766, 4'b1111, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 32'h32, 32'h55660000, 4'b1100, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 32'h30, 32'h0, 4'b0000, 32'h55667766, 1'b0));
    ops.push_back(mk(1'b1, 32'h30, 32'hAABB0000, 4'b1100, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 32'h30, 32'h0, 4'b0000, 32'h55667766, 1'b0));
    foreach (ops[i]) begin
      sb.push_back(exp_of(ops[i]));
      access(ops[i], got, lat, sc, rd, e);
      ex = sb.pop_front();
      checks++; if (!got || lat != 2 || sc != 2) begin errors++; $display("FAIL half_timing op%0d ack=%b lat %0d stall %0d need lat 2 stall 2", i, got, lat, sc); end
      checks++; if (e !== ex.err) begin errors++; $display("FAIL half_err op%0d got %b need %b", i, e, ex.err); end
      if (ex.chk_rd) begin
        checks++; if (rd !== ex.rdata) begin errors++; $display("FAIL half_rdata op%0d got %h need %h", i, rd, ex.rdata); end
      end
    end
  endtask

  task automatic test_errors();
    op_t ops[$];
    exp_t ex;
    logic got, e;
    int lat, sc;
    logic [31:0] rd;
    ops.push_back(mk(1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 32'h22, 32'h0, 4'b0000, 32'h1122BBAA, 1'b0));
    ops.push_back(mk(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 32'h1010, 32'h01020304, 4'b1111, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 32'h23, 32'hEE000000, 4'b0001, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 32'h20, 32'h0, 4'b0000, 32'h1122BBAA, 1'b0));
    ops.push_back(mk(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0));
    foreach (ops[i]) begin
      sb.push_back(exp_of(ops[i]));
      access(ops[i], got, lat, sc, rd, e);
      ex = sb.pop_front();
      checks++; if (!got || lat != 2 || sc != 2) begin errors++; $display("FAIL err_timing op%0d ack=%b lat %0d stall %0d need lat 2 stall 2", i, got, lat, sc); end
      checks++; if (e !== ex.err) begin errors++; $display("FAIL err_flag op%0d got %b need %b", i, e, ex.err); end
      if (ex.chk_rd) begin
        checks++; if (rd !== ex.rdata) begin errors++; $display("FAIL err_rdata op%0d got %h need %h", i, rd, ex.rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    exp_t ex;
    ops.push_back(mk(1'b1, 32'h100, 32'hA5A50001, 4'b1111, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 32'h104, 32'h5A5A0002, 4'b1111, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 32'h100, 32'h0, 4'b0000, 32'hA5A50001, 1'b0));
    ops.push_back(mk(1'b0, 32'h104, 32'h0, 4'b0000, 32'h5A5A0002, 1'b0));
    ops.push_back(mk(1'b0, 32'h2000, 32'h0, 4'b0000, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 32'h100, 32'h0, 4'b0000, 32'hA5A50001, 1'b0));
    foreach (ops[i]) begin
      @(negedge clk);
      cs1 = 1'b0; we1 = ops[i].w; addr1 = ops[i].a; wdata1 = ops[i].d; mask1 = ops[i].m;
      sb.push_back(exp_of(ops[i]));
      if (i == 0) begin
        #1;
        checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL b2b_accept_stall got %b need 1", stall1); end
      end else begin
        @(posedge clk); #1;
        checks++; if (ack1 !== 1'b0 || stall1 !== 1'b1) begin errors++; $display("FAIL b2b_gap op%0d ack %b stall %b need ack 0 stall 1", i, ack1, stall1); end
      end
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++; if (ack1 !== 1'b1 || stall1 !== 1'b0) begin errors++; $display("FAIL b2b_ack op%0d ack %b stall %b need ack 1 stall 0", i, ack1, stall1); end
      checks++; if (err1 !== ex.err) begin errors++; $display("FAIL b2b_err op%0d got %b need %b", i, err1, ex.err); end
      if (ex.chk_rd) begin
        checks++; if (rdata1 !== ex.rdata) begin errors++; $display("FAIL b2b_rdata op%0d got %h need %h", i, rdata1, ex.rdata); end
      end
    end
    @(negedge clk);
    cs1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++; if (ack1 !== 1'b0 || stall1 !== 1'b0) begin errors++; $display("FAIL b2b_quiet cyc%0d ack %b stall %b need 0 0", k, ack1, stall1); end
    end
  endtask

  task automatic test_reset_mid_access();
    op_t o;
    logic got, e;
    int lat, sc;
    logic [31:0] rd;
    o = mk(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
    access(o, got, lat, sc, rd, e);
    checks++; if (!got || e !== 1'b0) begin errors++; $display("FAIL rstmid_preload ack %b err %b need 1 0", got, e); end
    @(negedge clk);
    cs0 = 1'b0; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h12345678; mask0 = 4'b1111;
    @(posedge clk); #1;
    checks++; if (stall0 !== 1'b1 || u0.state !== WAIT) begin errors++; $display("FAIL rstmid_wait stall %b state %0d need 1 WAIT", stall0, u0.state); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (stall0 !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL rstmid_outputs stall %b ack %b need 0 0", stall0, ack0); end
    checks++; if (u0.state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d need IDLE", u0.state); end
    @(negedge clk);
    cs0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    o = mk(1'b0, 32'h40, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
    sb.push_back(exp_of(o));
    access(o, got, lat, sc, rd, e);
    begin
      exp_t ex;
      ex = sb.pop_front();
      checks++; if (!got || lat != 2) begin errors++; $display("FAIL rstmid_load_ack ack %b lat %0d need 1 2", got, lat); end
      checks++; if (rd !== ex.rdata || e !== ex.err) begin errors++; $display("FAIL rstmid_old_data got %h err %b need %h err %b", rd, e, ex.rdata, ex.err); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_merge();
    test_half_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
